t_to_s: RTL and testbench

T_TO_S -- requirements
Module: t_to_s

---
 rtl/t_to_s_pkg.sv | 23 ++
 rtl/t_to_s_conv.sv | 38 +++
 rtl/t_to_s.sv | 54 +++++
 tb/tb_t_to_s.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/t_to_s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : t_to_s_pkg                                               |
// | Brief   : Shared constants and helpers for the two's-complement to |
// |           sign-magnitude converter.                                |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package t_to_s_pkg;

   // Default input width in bits (two's-complement).
   localparam int DEFAULT_DATA_WIDTH = 6;

   // Sign bit position in the sign-magnitude output for the default width.
   localparam int SIGN_BIT_IDX = DEFAULT_DATA_WIDTH;

   // Sign bit position of the sign-magnitude output for any input width:
   // the sign sits directly above the DATA_WIDTH-bit magnitude.
   function automatic int sign_bit_idx(input int data_width);
      return data_width;
   endfunction

endpackage : t_to_s_pkg
`default_nettype wire

// File: rtl/t_to_s_conv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : t_to_s_conv                                              |
// | Brief   : Purely combinational two's-complement to sign-magnitude  |
// |           conversion.                                              |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module t_to_s_conv
   import t_to_s_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] inp,
   output logic [DATA_WIDTH:0]   out
);

   localparam int                  c_SIGN = sign_bit_idx(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] c_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic                  w_neg;
   logic [DATA_WIDTH-1:0] w_negated;
   logic [DATA_WIDTH-1:0] w_mag;

   // Magnitude is the input itself for non-negative values, otherwise its
   // DATA_WIDTH-bit negation; the most negative input wraps to 2^(W-1),
   // which is exactly its magnitude, so no saturation is needed. A negative
   // input can never yield a zero magnitude, so negative zero cannot occur.
   always_comb begin
      w_neg     = inp[DATA_WIDTH-1];
      w_negated = (~inp) + c_ONE;
      w_mag     = w_neg ? w_negated : inp;
      out       = '0;
      out[c_SIGN]           = w_neg;
      out[DATA_WIDTH-1:0]   = w_mag;
   end

endmodule : t_to_s_conv
`default_nettype wire

// File: rtl/t_to_s.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : t_to_s                                                   |
// | Brief   : Two's-complement to sign-magnitude converter with a      |
// |           zero-latency output and a 1-cycle registered output.     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module t_to_s
   import t_to_s_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] inp,
   input  logic                  in_valid,
   output logic [DATA_WIDTH:0]   out,
   output logic [DATA_WIDTH:0]   out_r,
   output logic                  out_valid
);

   logic [DATA_WIDTH:0] w_conv;
   logic [DATA_WIDTH:0] r_out;
   logic                r_valid;

   // Single converter feeds both the combinational output and the register.
   t_to_s_conv #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_conv (
      .inp (inp),
      .out (w_conv)
   );

   // Registered path: valid follows in_valid each cycle, data loads only on
   // valid beats and holds otherwise; reset clears both and drops anything
   // in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_out <= w_conv;
         end
      end
   end

   assign out       = w_conv;
   assign out_r     = r_out;
   assign out_valid = r_valid;

endmodule : t_to_s
`default_nettype wire

// File: tb/tb_t_to_s.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_t_to_s                                                |
// | Brief   : Directed self-checking bench for t_to_s (width 6).       |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_t_to_s;

   localparam int W = 6;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] inp;
   logic         in_valid;
   logic [W:0]   out;
   logic [W:0]   out_r;
   logic         out_valid;

   int checks;
   int errors;

   t_to_s #(
      .DATA_WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inp       (inp),
      .in_valid  (in_valid),
      .out       (out),
      .out_r     (out_r),
      .out_valid (out_valid)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      inp      = 6'b111110;
      tick();
      tick();
      checks++;
      if (out_r !== 7'b0000000) begin
         errors++;
         $display("FAIL reset_out_r actual=%b required=%b", out_r, 7'b0000000);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid actual=%b required=%b", out_valid, 1'b0);
      end
      checks++;
      if (out !== 7'b1000010) begin
         errors++;
         $display("FAIL reset_comb_out actual=%b required=%b", out, 7'b1000010);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] vin [5];
      logic [W:0]   vexp[5];
      vin[0] = 6'b000000; vexp[0] = 7'b0000000;
      vin[1] = 6'b011111; vexp[1] = 7'b0011111;
      vin[2] = 6'b111111; vexp[2] = 7'b1000001;
      vin[3] = 6'b100001; vexp[3] = 7'b1011111;
      vin[4] = 6'b100000; vexp[4] = 7'b1100000;
      for (int i = 0; i < 5; i++) begin
         inp = vin[i];
         #1;
         checks++;
         if (out !== vexp[i]) begin
            errors++;
            $display("FAIL directed[%0d] inp=%b actual=%b required=%b", i, vin[i], out, vexp[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [W:0] exp_out;
      int         sweep_err;
      sweep_err = 0;
      for (int v = 0; v < 64; v++) begin
         inp = 6'(v);
         #10;
         if (v < 32) exp_out = 7'(v);
         else        exp_out = 7'd64 | 7'(64 - v);
         checks++;
         if (out !== exp_out) begin
            errors++;
            sweep_err++;
            if (sweep_err <= 8)
               $display("FAIL sweep inp=%0d actual=%b required=%b", v, out, exp_out);
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      inp      = 6'b111110;
      tick();
      checks++;
      if (out_r !== 7'b1000010 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reg_load actual=%b/%b required=%b/%b", out_r, out_valid, 7'b1000010, 1'b1);
      end
      in_valid = 1'b0;
      inp      = 6'b000101;
      tick();
      checks++;
      if (out_r !== 7'b1000010 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reg_hold actual=%b/%b required=%b/%b", out_r, out_valid, 7'b1000010, 1'b0);
      end
      checks++;
      if (out !== 7'b0000101) begin
         errors++;
         $display("FAIL reg_hold_comb actual=%b required=%b", out, 7'b0000101);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] vin [3];
      logic [W:0]   vexp[3];
      vin[0] = 6'b000011; vexp[0] = 7'b0000011;
      vin[1] = 6'b111111; vexp[1] = 7'b1000001;
      vin[2] = 6'b100000; vexp[2] = 7'b1100000;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inp = vin[i];
         tick();
         checks++;
         if (out_r !== vexp[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b[%0d] actual=%b/%b required=%b/%b", i, out_r, out_valid, vexp[i], 1'b1);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1;
      inp      = 6'b000111;
      tick();
      checks++;
      if (out_r !== 7'b0000111 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre actual=%b/%b required=%b/%b", out_r, out_valid, 7'b0000111, 1'b1);
      end
      rst_n = 1'b0;
      inp   = 6'b101010;
      tick();
      checks++;
      if (out_r !== 7'b0000000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst actual=%b/%b required=%b/%b", out_r, out_valid, 7'b0000000, 1'b0);
      end
      checks++;
      if (out !== 7'b1010110) begin
         errors++;
         $display("FAIL mid_rst_comb actual=%b required=%b", out, 7'b1010110);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_r !== 7'b0000000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_idle actual=%b/%b required=%b/%b", out_r, out_valid, 7'b0000000, 1'b0);
      end
      in_valid = 1'b1;
      inp      = 6'b000010;
      tick();
      checks++;
      if (out_r !== 7'b0000010 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_first actual=%b/%b required=%b/%b", out_r, out_valid, 7'b0000010, 1'b1);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      inp      = '0;
      test_reset();
      test_directed();
      test_sweep();
      test_registered();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_t_to_s
`default_nettype wire
